// File: rtl/histogram_peak_tracker.sv
// histogram_peak_tracker
// Watches the read-back side of a histogram stage for one frame of samples
// and reports the bin with the highest count, its count, and whether any
// sample in the frame returned a saturated count. The sample strobe is
// delayed by one cycle so each bin index lines up with the count that the
// histogram memory returns for it one cycle later.
module histogram_peak_tracker #(
    parameter int SIZE       = 5,
    parameter int MAX_NUMBER = 127,
    parameter int FRAME_LEN  = 1024,
    localparam int BIN_W     = $clog2(MAX_NUMBER)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENA,
    input  logic [BIN_W-1:0] d_in,
    input  logic [SIZE-1:0]  mem_out,
    input  logic             start,
    input  logic             peak_ready,
    output logic             peak_valid,
    output logic [BIN_W-1:0] peak_bin,
    output logic [SIZE-1:0]  peak_count,
    output logic             peak_sat,
    output logic             busy
);

    localparam int               CNT_W      = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN);
    localparam logic [SIZE-1:0]  SAT_VAL    = {SIZE{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state_q;
    logic [BIN_W-1:0] d_q;
    logic             v_q;
    logic [SIZE-1:0]  best_q;
    logic [BIN_W-1:0] bin_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             busy_q;

    logic             pair_cnt;
    logic [CNT_W-1:0] cnt_d;

    // A count is saturated when every bit of the histogram counter is set.
    function automatic logic is_sat(input logic [SIZE-1:0] c);
        return c == SAT_VAL;
    endfunction

    // Qualify the aligned (bin, count) pair and precompute the next sample count.
    always_comb begin
        pair_cnt = (state_q == TRACK) && v_q;
        cnt_d    = cnt_q + CNT_W'(1);
    end

    // Alignment stage plus frame FSM; all outputs are registered here.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            d_q     <= '0;
            v_q     <= 1'b0;
            best_q  <= '0;
            bin_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // Strobes seen outside TRACK never become pairs.
            d_q <= d_in;
            v_q <= ENA && (state_q == TRACK);

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= TRACK;
                        best_q  <= '0;
                        bin_q   <= '0;
                        sat_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                TRACK: begin
                    if (pair_cnt) begin
                        cnt_q <= cnt_d;
                        // Strict compare so a tie keeps the earlier bin.
                        if (mem_out > best_q) begin
                            best_q <= mem_out;
                            bin_q  <= d_q;
                        end
                        if (is_sat(mem_out)) begin
                            sat_q <= 1'b1;
                        end
                        // The closing pair is folded in on the same edge that enters REPORT.
                        if (cnt_d == FRAME_LAST) begin
                            state_q <= REPORT;
                            valid_q <= 1'b1;
                        end
                    end
                end

                REPORT: begin
                    // Results stay visible after the handshake until the next start.
                    if (peak_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign peak_valid = valid_q;
    assign peak_bin   = bin_q;
    assign peak_count = best_q;
    assign peak_sat   = sat_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_histogram_peak_tracker.sv
// Directed bench for histogram_peak_tracker with a 4-sample frame.
module tb_histogram_peak_tracker;

    localparam int SIZE = 5;
    localparam int MAXN = 127;
    localparam int FL   = 4;
    localparam int BW   = 7;

    logic          CLK;
    logic          RST;
    logic          ENA;
    logic [BW-1:0] d_in;
    logic [SIZE-1:0] mem_out;
    logic          start;
    logic          peak_ready;
    logic          peak_valid;
    logic [BW-1:0] peak_bin;
    logic [SIZE-1:0] peak_count;
    logic          peak_sat;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    histogram_peak_tracker #(
        .SIZE      (SIZE),
        .MAX_NUMBER(MAXN),
        .FRAME_LEN (FL)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ENA       (ENA),
        .d_in      (d_in),
        .mem_out   (mem_out),
        .start     (start),
        .peak_ready(peak_ready),
        .peak_valid(peak_valid),
        .peak_bin  (peak_bin),
        .peak_count(peak_count),
        .peak_sat  (peak_sat),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic            s;
        logic            e;
        logic [BW-1:0]   d;
        logic [SIZE-1:0] m;
        logic            r;
        logic            ev;
        logic [BW-1:0]   eb;
        logic [SIZE-1:0] ec;
        logic            es;
        logic            ebz;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic ev, input logic [BW-1:0] eb,
                         input logic [SIZE-1:0] ec, input logic es, input logic ebz);
        checks++;
        if ({peak_valid, peak_bin, peak_count, peak_sat, busy} !== {ev, eb, ec, es, ebz}) begin
            failures++;
            $display("FAIL %s: got valid=%0b bin=%0d count=%0d sat=%0b busy=%0b, want valid=%0b bin=%0d count=%0d sat=%0b busy=%0b",
                     name, peak_valid, peak_bin, peak_count, peak_sat, busy, ev, eb, ec, es, ebz);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle just after the rising edge.
    task automatic apply(input logic s, input logic e, input logic [BW-1:0] d,
                         input logic [SIZE-1:0] m, input logic r);
        @(negedge CLK);
        start      = s;
        ENA        = e;
        d_in       = d;
        mem_out    = m;
        peak_ready = r;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //            s  e  d   m   r   v  bin cnt sat busy
        tbl[0]  = '{1, 0, 0,  0,  0,  0, 0,  0,  0, 1};
        tbl[1]  = '{0, 1, 5,  0,  0,  0, 0,  0,  0, 1};
        tbl[2]  = '{0, 1, 9,  1,  0,  0, 5,  1,  0, 1};
        tbl[3]  = '{0, 1, 12, 3,  0,  0, 9,  3,  0, 1};
        tbl[4]  = '{0, 1, 20, 2,  0,  0, 9,  3,  0, 1};
        tbl[5]  = '{0, 0, 0,  3,  0,  1, 9,  3,  0, 1};
        tbl[6]  = '{0, 0, 0,  0,  0,  1, 9,  3,  0, 1};
        tbl[7]  = '{0, 0, 0,  0,  1,  0, 9,  3,  0, 0};
        tbl[8]  = '{0, 1, 3,  31, 0,  0, 9,  3,  0, 0};
        tbl[9]  = '{0, 1, 3,  31, 0,  0, 9,  3,  0, 0};
        tbl[10] = '{1, 0, 0,  0,  0,  0, 0,  0,  0, 1};
        tbl[11] = '{0, 1, 40, 0,  0,  0, 0,  0,  0, 1};
        tbl[12] = '{0, 1, 41, 31, 0,  0, 40, 31, 1, 1};
        tbl[13] = '{0, 1, 42, 31, 0,  0, 40, 31, 1, 1};
        tbl[14] = '{0, 1, 43, 5,  0,  0, 40, 31, 1, 1};
        tbl[15] = '{0, 0, 0,  2,  0,  1, 40, 31, 1, 1};
        tbl[16] = '{0, 0, 0,  0,  1,  0, 40, 31, 1, 0};

        RST        = 1'b0;
        ENA        = 1'b0;
        d_in       = '0;
        mem_out    = '0;
        start      = 1'b0;
        peak_ready = 1'b0;
        #1;
        check("reset_state", 0, 0, 0, 0, 0);

        @(negedge CLK);
        RST = 1'b1;
        apply(0, 0, 0, 0, 0);
        check("idle_after_release", 0, 0, 0, 0, 0);

        // Basic frame with a tie, drop in IDLE, then a saturated frame.
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].m, tbl[i].r);
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eb, tbl[i].ec, tbl[i].es, tbl[i].ebz);
        end

        // Back-pressure in REPORT: outputs frozen, start and ENA ignored.
        apply(1, 0, 0, 0, 0);
        check("bp_start", 0, 0, 0, 0, 1);
        apply(0, 1, 10, 0, 0);
        apply(0, 1, 11, 4, 0);
        apply(0, 1, 12, 8, 0);
        apply(0, 1, 13, 8, 0);
        check("bp_pre_report", 0, 11, 8, 0, 1);
        apply(0, 0, 0, 1, 0);
        check("bp_report", 1, 11, 8, 0, 1);
        for (int i = 0; i < 10; i++) begin
            apply((i == 2) || (i == 6), i[0], BW'(i + 50), 31, 0);
            check($sformatf("bp_hold%0d", i), 1, 11, 8, 0, 1);
        end
        apply(0, 0, 0, 0, 1);
        check("bp_release", 0, 11, 8, 0, 0);
        apply(0, 0, 0, 0, 0);
        check("bp_idle_after", 0, 11, 8, 0, 0);

        // Long ENA stall mid-frame: counter holds, frame ends after 4 counted pairs.
        apply(1, 0, 0, 0, 0);
        check("stall_start", 0, 0, 0, 0, 1);
        apply(0, 1, 1, 0, 0);
        apply(0, 1, 2, 6, 0);
        check("stall_pair1", 0, 1, 6, 0, 1);
        apply(0, 0, 0, 9, 0);
        check("stall_pair2", 0, 2, 9, 0, 1);
        for (int i = 0; i < 19; i++) begin
            apply(0, 0, 0, 31, 0);
            check($sformatf("stall%0d", i), 0, 2, 9, 0, 1);
        end
        apply(0, 1, 3, 0, 0);
        check("stall_resume", 0, 2, 9, 0, 1);
        apply(0, 1, 4, 2, 0);
        check("stall_pair3", 0, 2, 9, 0, 1);
        apply(0, 0, 0, 1, 0);
        check("stall_report", 1, 2, 9, 0, 1);
        apply(0, 0, 0, 0, 1);
        check("stall_release", 0, 2, 9, 0, 0);

        // Asynchronous reset in the middle of TRACK.
        apply(1, 0, 0, 0, 0);
        apply(0, 1, 7, 0, 0);
        apply(0, 1, 8, 31, 0);
        check("rst_pre", 0, 7, 31, 1, 1);
        #2;
        RST = 1'b0;
        #1;
        check("rst_async", 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        check("rst_held", 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;

        // ENA without start after reset: nothing may happen.
        for (int i = 0; i < 50; i++) begin
            apply(0, 1, BW'(i), 31, i[0]);
            check($sformatf("idle_ena%0d", i), 0, 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
